cpu_stage_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32 core datapath (fetch, decode, ALU, data memory, writeback/next-PC). Steps one instruction at a time through the stages and owns the instruction- and data-memory request handshakes. Generates the write strobes that commit the writeback mux result to the regfile and the next-PC result to the PC register. Bus timeouts, illegal decode combinations and halt instructions drive it into sticky terminal states.

---
 rtl/cpu_stage_ctrl.sv | 135 +++++++++++++
 tb/tb_cpu_stage_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_stage_ctrl.sv
// Multi-cycle stage sequencer for the RV32 datapath: fetch/decode/exec/mem/writeback.
// Optional macro PERF_CNT_EN adds cycle_cnt and instret_cnt performance counters.
module cpu_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic        reg_wen,
    input  logic        halt_ins,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            timeout_hit;

    // tcnt holds (request cycles elapsed - 1); the last legal ack cycle sees TIMEOUT-1.
    assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // tcnt_d defaults to zero so every entry to FETCH/MEM starts a fresh window.
    always_comb begin
        state_d = state_q;
        tcnt_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack)         state_d = S_DECODE;
                else if (timeout_hit) state_d = S_ERR;
                else                  tcnt_d  = tcnt_q + TW'(1);
            end
            S_DECODE: begin
                state_d = halt_ins ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (mem_ren && mem_wen)      state_d = S_ERR;
                else if (mem_ren || mem_wen) state_d = S_MEM;
                else                         state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ack)         state_d = S_WB;
                else if (timeout_hit) state_d = S_ERR;
                else                  tcnt_d  = tcnt_q + TW'(1);
            end
            S_WB: begin
                state_d = run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        imem_req = (state_q == S_FETCH);
        dmem_req = (state_q == S_MEM);
        dmem_we  = (state_q == S_MEM) && mem_wen;
        ir_we    = (state_q == S_FETCH) && imem_ack;
        pc_we    = (state_q == S_WB);
        reg_we   = (state_q == S_WB) && reg_wen;
        halted   = (state_q == S_HALT);
        err      = (state_q == S_ERR);
    end

    assign state = state_q;

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_IDLE && state_q != S_HALT && state_q != S_ERR)
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (state_q == S_WB)
            instret_cnt_d = instret_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_stage_ctrl.sv
// Directed scoreboard bench for cpu_stage_ctrl; expected per-cycle outputs are queued then compared.
module tb_cpu_stage_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DEC = 3'd2, EXEC = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6, ERR = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic mem_ren = 1'b0, mem_wen = 1'b0, reg_wen = 1'b0, halt_ins = 1'b0;
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, halted, err;
    logic [2:0] state;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_stage_ctrl #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .reg_wen(reg_wen), .halt_ins(halt_ins),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
        .pc_we(pc_we), .reg_we(reg_we), .halted(halted), .err(err), .state(state)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // Expected output vector {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, halted, err}
    function automatic logic [10:0] model(input logic [2:0] st, input logic wen,
                                          input logic rwen, input logic iack);
        return {st, st == FETCH, st == MEM, (st == MEM) && wen, (st == FETCH) && iack,
                st == WB, (st == WB) && rwen, st == HALT, st == ERR};
    endfunction

    task automatic check(input string tag);
        logic [10:0] exp_v;
        logic [10:0] obs_v;
        exp_v = exp_q.pop_front();
        obs_v = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, halted, err};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs_v, exp_v);
        end
        $display("t=%0t %s state=%0d outs=%b", $time, tag, state, obs_v[7:0]);
    endtask

    task automatic cyc(input logic r, input logic ia, input logic da, input logic ren,
                       input logic wen, input logic rwen, input logic hlt,
                       input logic [2:0] st, input string tag);
        @(negedge clk);
        run = r; imem_ack = ia; dmem_ack = da;
        mem_ren = ren; mem_wen = wen; reg_wen = rwen; halt_ins = hlt;
        exp_q.push_back(model(st, wen, rwen, ia));
        #1;
        check(tag);
    endtask

    // Asserts reset mid-cycle and checks the asynchronous effect before any clock edge.
    task automatic rst_pulse(input string tag);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        mem_ren = 1'b0; mem_wen = 1'b0; reg_wen = 1'b0; halt_ins = 1'b0;
        exp_q.push_back(model(IDLE, 1'b0, 1'b0, 1'b0));
        #1;
        check(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, IDLE, "reset_hold");
        rst_pulse("reset_state");

        // ALU op, zero-wait fetch
        cyc(1, 0, 0, 0, 0, 1, 0, IDLE,  "alu_idle");
        cyc(1, 1, 0, 0, 0, 1, 0, FETCH, "alu_fetch");
        cyc(1, 0, 0, 0, 0, 1, 0, DEC,   "alu_dec");
        cyc(1, 0, 0, 0, 0, 1, 0, EXEC,  "alu_exec");
        cyc(1, 0, 0, 0, 0, 1, 0, WB,    "alu_wb");

        // Load, 3 wait cycles in MEM
        cyc(1, 1, 0, 1, 0, 1, 0, FETCH, "ld_fetch");
        cyc(1, 0, 0, 1, 0, 1, 0, DEC,   "ld_dec");
        cyc(1, 0, 0, 1, 0, 1, 0, EXEC,  "ld_exec");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 1, 0, MEM, "ld_mem_wait");
        cyc(1, 0, 1, 1, 0, 1, 0, MEM,   "ld_mem_ack");
        cyc(1, 0, 0, 1, 0, 1, 0, WB,    "ld_wb");

        // Store with reg_wen=1
        cyc(1, 1, 0, 0, 1, 1, 0, FETCH, "st_fetch");
        cyc(1, 0, 0, 0, 1, 1, 0, DEC,   "st_dec");
        cyc(1, 0, 0, 0, 1, 1, 0, EXEC,  "st_exec");
        cyc(1, 0, 1, 0, 1, 1, 0, MEM,   "st_mem");
        cyc(1, 0, 0, 0, 1, 1, 0, WB,    "st_wb");

        // Load with run dropped during MEM, then stray acks in IDLE
        cyc(1, 1, 0, 1, 0, 0, 0, FETCH, "rd_fetch");
        cyc(1, 0, 0, 1, 0, 0, 0, DEC,   "rd_dec");
        cyc(1, 0, 0, 1, 0, 0, 0, EXEC,  "rd_exec");
        cyc(0, 0, 0, 1, 0, 0, 0, MEM,   "rd_mem_norun");
        cyc(0, 0, 1, 1, 0, 0, 0, MEM,   "rd_mem_ack");
        cyc(0, 0, 0, 1, 0, 0, 0, WB,    "rd_wb");
        cyc(0, 1, 1, 0, 0, 0, 0, IDLE,  "stray_ack_idle");
        cyc(0, 1, 1, 0, 0, 0, 0, IDLE,  "stray_ack_idle2");

        // Fetch ack on the last legal cycle, then MEM ack on the last legal cycle
        cyc(1, 0, 0, 1, 0, 1, 0, IDLE,  "edge_idle");
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(1, 0, 0, 1, 0, 1, 0, FETCH, "edge_fetch_wait");
        cyc(1, 1, 0, 1, 0, 1, 0, FETCH, "edge_fetch_lastack");
        cyc(1, 0, 0, 1, 0, 1, 0, DEC,   "edge_dec");
        cyc(1, 0, 0, 1, 0, 1, 0, EXEC,  "edge_exec");
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(1, 0, 0, 1, 0, 1, 0, MEM, "edge_mem_wait");
        cyc(0, 0, 1, 1, 0, 1, 0, MEM,   "edge_mem_lastack");
        cyc(0, 0, 0, 1, 0, 1, 0, WB,    "edge_wb");
        cyc(0, 0, 0, 0, 0, 0, 0, IDLE,  "edge_idle_after");

        // Illegal load+store decode
        cyc(1, 0, 0, 0, 0, 0, 0, IDLE,  "ill_idle");
        cyc(1, 1, 0, 1, 1, 0, 0, FETCH, "ill_fetch");
        cyc(1, 0, 0, 1, 1, 0, 0, DEC,   "ill_dec");
        cyc(1, 0, 0, 1, 1, 0, 0, EXEC,  "ill_exec");
        cyc(1, 1, 1, 0, 0, 0, 0, ERR,   "ill_err");
        cyc(1, 1, 1, 0, 0, 0, 0, ERR,   "ill_err_sticky");
        rst_pulse("ill_reset");

        // Fetch timeout
        cyc(1, 0, 0, 0, 0, 0, 0, IDLE,  "to_idle");
        for (int i = 0; i < TIMEOUT; i++) cyc(1, 0, 0, 0, 0, 0, 0, FETCH, "to_fetch_wait");
        cyc(1, 0, 0, 0, 0, 0, 0, ERR,   "to_err");
        cyc(1, 1, 0, 0, 0, 0, 0, ERR,   "to_late_ack");
        cyc(1, 0, 0, 0, 0, 0, 0, ERR,   "to_err_sticky");
        rst_pulse("to_reset");

        // Halt instruction
        cyc(1, 0, 0, 0, 0, 1, 1, IDLE,  "halt_idle");
        cyc(1, 1, 0, 0, 0, 1, 1, FETCH, "halt_fetch");
        cyc(1, 0, 0, 0, 0, 1, 1, DEC,   "halt_dec");
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 1, 1, HALT, "halt_sticky");
        rst_pulse("halt_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, IDLE,  "halt_after_reset");

        // Reset while a fetch is outstanding
        cyc(1, 0, 0, 0, 0, 0, 0, IDLE,  "mf_idle");
        cyc(1, 0, 0, 0, 0, 0, 0, FETCH, "mf_fetch");
        rst_pulse("mf_async_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, IDLE,  "mf_idle_after");

`ifdef PERF_CNT_EN
        rst_pulse("perf_reset");
        checks++;
        assert (cycle_cnt === 32'd0 && instret_cnt === 32'd0) else begin
            errors++;
            $error("FAIL perf_reset observed %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
        end
        cyc(1, 0, 0, 0, 0, 1, 0, IDLE, "perf_idle");
        for (int n = 0; n < 3; n++) begin
            cyc(1, 1, 0, 0, 0, 1, 0, FETCH, "perf_fetch");
            cyc(1, 0, 0, 0, 0, 1, 0, DEC,   "perf_dec");
            cyc(1, 0, 0, 0, 0, 1, 0, EXEC,  "perf_exec");
            cyc(n != 2, 0, 0, 0, 0, 1, 0, WB, "perf_wb");
        end
        cyc(0, 0, 0, 0, 0, 0, 0, IDLE, "perf_done");
        checks++;
        assert (instret_cnt === 32'd3) else begin
            errors++;
            $error("FAIL perf_instret observed %0d expected 3", instret_cnt);
        end
        checks++;
        assert (cycle_cnt === 32'd12) else begin
            errors++;
            $error("FAIL perf_cycle observed %0d expected 12", cycle_cnt);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
